// File: rtl/qpsk_demapper_serializer_if.sv
// rtl/qpsk_demapper_serializer_if.sv - symbol-in / bit-out handshake bundle for the QPSK demapper
interface qpsk_demapper_serializer_if;
    logic        valid_in;
    logic [15:0] I_comp;
    logic [15:0] Q_comp;
    logic        ready_out;
    logic        data_out;
    logic        valid_out;
    logic        ready_in;
    logic        block_done;
    logic        sym_err;
    logic [7:0]  err_count;

    modport slave (
        input  valid_in, I_comp, Q_comp, ready_in,
        output ready_out, data_out, valid_out, block_done, sym_err, err_count
    );

    modport master (
        output valid_in, I_comp, Q_comp, ready_in,
        input  ready_out, data_out, valid_out, block_done, sym_err, err_count
    );
endinterface

// File: rtl/qpsk_demapper_serializer.sv
// rtl/qpsk_demapper_serializer.sv - QPSK hard-decision demapper with symbol FIFO and 1-bit serializer
// Flags off-constellation symbols and pulses block_done at each interleaver-block boundary.
module qpsk_demapper_serializer #(
    parameter int          DEPTH      = 4,
    parameter int          BLOCK_SYMS = 96,
    parameter logic [15:0] POS_LEVEL  = 16'h5A82,
    parameter logic [15:0] NEG_LEVEL  = 16'hA57E
) (
    input  logic                          clk_100,
    input  logic                          reset_N,
    qpsk_demapper_serializer_if.slave     bus
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = $clog2(BLOCK_SYMS);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0]  BLK_LAST = CW'(BLOCK_SYMS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_I = 2'd1,
        SEND_Q = 2'd2
    } state_t;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [1:0]    head;
    logic          bad_i;
    logic          bad_q;

    state_t        state;
    logic          data_r;
    logic          valid_r;
    logic          q_bit;
    logic [CW-1:0] blk_cnt;
    logic          done_r;
    logic          err_r;
    logic [7:0]    err_cnt_r;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = bus.valid_in && !full;
    assign head  = mem[rptr];

    // The serializer pulls the next symbol when idle, or when the Q bit of the
    // current one is being accepted, so back-to-back symbols leave no bubble.
    assign pop = !empty && ((state == IDLE) || ((state == SEND_Q) && bus.ready_in));

    assign bad_i = (bus.I_comp != POS_LEVEL) && (bus.I_comp != NEG_LEVEL);
    assign bad_q = (bus.Q_comp != POS_LEVEL) && (bus.Q_comp != NEG_LEVEL);

    always_ff @(posedge clk_100) begin
        if (push) begin
            mem[wptr] <= {bus.I_comp[15], bus.Q_comp[15]};
        end
    end

    always_ff @(posedge clk_100 or negedge reset_N) begin
        if (!reset_N) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_100 or negedge reset_N) begin
        if (!reset_N) begin
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            err_r <= push && (bad_i || bad_q);
            if (push && (bad_i || bad_q) && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100 or negedge reset_N) begin
        if (!reset_N) begin
            state   <= IDLE;
            data_r  <= 1'b0;
            valid_r <= 1'b0;
            q_bit   <= 1'b0;
            blk_cnt <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        data_r  <= head[1];
                        q_bit   <= head[0];
                        valid_r <= 1'b1;
                        state   <= SEND_I;
                    end
                end
                SEND_I: begin
                    if (bus.ready_in) begin
                        data_r <= q_bit;
                        state  <= SEND_Q;
                    end
                end
                SEND_Q: begin
                    if (bus.ready_in) begin
                        if (blk_cnt == BLK_LAST) begin
                            blk_cnt <= '0;
                            done_r  <= 1'b1;
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                        end
                        if (pop) begin
                            data_r <= head[1];
                            q_bit  <= head[0];
                            state  <= SEND_I;
                        end else begin
                            valid_r <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_out  = !full;
    assign bus.data_out   = data_r;
    assign bus.valid_out  = valid_r;
    assign bus.block_done = done_r;
    assign bus.sym_err    = err_r;
    assign bus.err_count  = err_cnt_r;

endmodule

// File: tb/tb_qpsk_demapper_serializer.sv
// tb/tb_qpsk_demapper_serializer.sv - table-driven and sequence bench for qpsk_demapper_serializer
module tb_qpsk_demapper_serializer;

    localparam int          DEPTH      = 4;
    localparam int          BLOCK_SYMS = 96;
    localparam int          BLOCK_BITS = 2 * BLOCK_SYMS;
    localparam logic [15:0] POS        = 16'h5A82;
    localparam logic [15:0] NEG        = 16'hA57E;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [1:0]  bits;
        logic        err;
    } vec_t;

    logic clk_100 = 1'b0;
    logic reset_N = 1'b0;
    always #5 clk_100 = ~clk_100;

    qpsk_demapper_serializer_if bus();

    qpsk_demapper_serializer #(
        .DEPTH(DEPTH), .BLOCK_SYMS(BLOCK_SYMS), .POS_LEVEL(POS), .NEG_LEVEL(NEG)
    ) dut (
        .clk_100 (clk_100),
        .reset_N (reset_N),
        .bus     (bus)
    );

    int   n_vec  = 0;
    int   n_fail = 0;
    bit   exp_q[$];
    int   errc   = 0;
    int   nbits  = 0;
    int   n_done = 0;
    int   pushes;
    int   guard;
    logic was_ready;
    vec_t tbl[8];
    vec_t bp[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_bad(input logic [15:0] v);
        return (v != POS) && (v != NEG);
    endfunction

    // One clock with a reference model: handshakes are judged from the values
    // visible just before the edge, outputs are compared just after it.
    task automatic cyc();
        logic        pushed, acc, held, d, bad;
        logic [15:0] iv, qv;
        pushed = bus.valid_in && bus.ready_out;
        acc    = bus.valid_out && bus.ready_in;
        held   = bus.valid_out && !bus.ready_in;
        d      = bus.data_out;
        iv     = bus.I_comp;
        qv     = bus.Q_comp;
        bad    = is_bad(iv) || is_bad(qv);
        @(posedge clk_100);
        #1;
        if (acc) begin
            nbits++;
            if (exp_q.size() == 0) check("extra_bit", 32'd1, 32'd0);
            else                   check("bit_order", d, exp_q.pop_front());
        end
        if (pushed) begin
            exp_q.push_back(iv[15]);
            exp_q.push_back(qv[15]);
            if (bad && errc < 255) errc++;
        end
        if (held) begin
            check("hold_valid", bus.valid_out, 1);
            check("hold_data", bus.data_out, d);
        end
        check("sym_err", bus.sym_err, pushed && bad);
        check("err_count", bus.err_count, errc);
        check("block_done", bus.block_done, acc && (nbits % BLOCK_BITS == 0));
        n_done += bus.block_done;
    endtask

    task automatic apply_reset();
        @(posedge clk_100);
        #1;
        reset_N = 1'b0;
        #1;
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_sym_err", bus.sym_err, 0);
        check("rst_block_done", bus.block_done, 0);
        check("rst_ready_out", bus.ready_out, 1);
        exp_q.delete();
        errc  = 0;
        nbits = 0;
        @(posedge clk_100);
        #1;
        reset_N = 1'b1;
    endtask

    task automatic drain();
        int k;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || bus.valid_out) && k < 400) begin
            cyc();
            k++;
        end
        check("drain_timeout", exp_q.size(), 0);
        cyc();
        check("drained_idle", bus.valid_out, 0);
    endtask

    initial begin
        tbl[0] = '{NEG, POS, 2'b10, 1'b0};
        tbl[1] = '{POS, POS, 2'b00, 1'b0};
        tbl[2] = '{NEG, NEG, 2'b11, 1'b0};
        tbl[3] = '{POS, NEG, 2'b01, 1'b0};
        tbl[4] = '{16'h4000, POS, 2'b00, 1'b1};
        tbl[5] = '{16'h8000, 16'h0000, 2'b10, 1'b1};
        tbl[6] = '{POS, 16'hC000, 2'b01, 1'b1};
        tbl[7] = '{16'h7FFF, 16'hFFFF, 2'b01, 1'b1};
        bp[0] = '{NEG, POS, 2'b10, 1'b0};
        bp[1] = '{POS, NEG, 2'b01, 1'b0};
        bp[2] = '{NEG, NEG, 2'b11, 1'b0};
        bp[3] = '{POS, POS, 2'b00, 1'b0};
        bp[4] = '{NEG, POS, 2'b10, 1'b0};
        bp[5] = '{POS, NEG, 2'b01, 1'b0};

        bus.valid_in = 1'b0;
        bus.I_comp   = '0;
        bus.Q_comp   = '0;
        bus.ready_in = 1'b0;
        apply_reset();
        cyc();
        check("post_rst_ready", bus.ready_out, 1);

        // Single symbols: push at edge N, I bit after N+1, Q bit after N+2, idle after N+3.
        for (int v = 0; v < 8; v++) begin
            bus.valid_in = 1'b1;
            bus.I_comp   = tbl[v].i;
            bus.Q_comp   = tbl[v].q;
            bus.ready_in = 1'b1;
            cyc();
            check("tv_sym_err", bus.sym_err, tbl[v].err);
            check("tv_no_early_valid", bus.valid_out, 0);
            bus.valid_in = 1'b0;
            cyc();
            check("tv_valid_i", bus.valid_out, 1);
            check("tv_bit_i", bus.data_out, tbl[v].bits[1]);
            cyc();
            check("tv_valid_q", bus.valid_out, 1);
            check("tv_bit_q", bus.data_out, tbl[v].bits[0]);
            cyc();
            check("tv_idle", bus.valid_out, 0);
        end
        check("tbl_err_count", bus.err_count, 4);

        // Backpressure: FIFO holds DEPTH symbols plus one in the serializer.
        bus.ready_in = 1'b0;
        pushes = 0;
        for (int c = 0; c < 10; c++) begin
            bus.valid_in = (pushes < 6);
            bus.I_comp   = bp[pushes % 6].i;
            bus.Q_comp   = bp[pushes % 6].q;
            was_ready    = bus.ready_out;
            cyc();
            if (was_ready && pushes < 6) pushes++;
        end
        check("bp_accepted", pushes, DEPTH + 1);
        check("bp_ready_low", bus.ready_out, 0);
        check("bp_held_valid", bus.valid_out, 1);
        check("bp_held_data", bus.data_out, bp[0].bits[1]);
        bus.ready_in = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check("bp_no_bubble", bus.valid_out, 1);
            bus.valid_in = (pushes < 6);
            bus.I_comp   = bp[pushes % 6].i;
            bus.Q_comp   = bp[pushes % 6].q;
            was_ready    = bus.ready_out;
            cyc();
            if (was_ready && pushes < 6) pushes++;
        end
        check("bp_all_pushed", pushes, 6);
        check("bp_empty_after", bus.valid_out, 0);
        drain();

        // Off-constellation saturation
        bus.ready_in = 1'b1;
        bus.I_comp   = 16'h4000;
        bus.Q_comp   = POS;
        pushes = 0;
        guard  = 0;
        while (pushes < 300 && guard < 3000) begin
            bus.valid_in = 1'b1;
            was_ready    = bus.ready_out;
            cyc();
            if (was_ready) pushes++;
            guard++;
        end
        check("sat_pushes", pushes, 300);
        drain();
        check("err_saturated", bus.err_count, 8'hFF);

        // Reset in the middle of a stream discards everything
        bus.ready_in = 1'b0;
        bus.I_comp   = NEG;
        bus.Q_comp   = NEG;
        bus.valid_in = 1'b1;
        for (int c = 0; c < 3; c++) cyc();
        bus.valid_in = 1'b0;
        check("pre_rst_valid", bus.valid_out, 1);
        apply_reset();
        bus.ready_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            check("rst_discard_idle", bus.valid_out, 0);
            check("rst_discard_ready", bus.ready_out, 1);
        end

        // Two interleaver blocks streamed continuously
        n_done = 0;
        pushes = 0;
        guard  = 0;
        bus.ready_in = 1'b1;
        while (pushes < 2 * BLOCK_SYMS && guard < 2000) begin
            bus.valid_in = 1'b1;
            bus.I_comp   = (pushes % 3 == 0) ? NEG : POS;
            bus.Q_comp   = (pushes % 5 == 0) ? NEG : POS;
            was_ready    = bus.ready_out;
            cyc();
            if (was_ready) pushes++;
            guard++;
        end
        drain();
        check("block_bits", nbits, 2 * BLOCK_BITS);
        check("block_pulses", n_done, 2);

        // Random valid/ready over 1000 symbols
        pushes = 0;
        guard  = 0;
        bus.valid_in = 1'b0;
        while (pushes < 1000 && guard < 20000) begin
            if (!(bus.valid_in && !bus.ready_out)) begin
                bus.valid_in = ($urandom_range(0, 2) != 0);
                bus.I_comp   = ($urandom_range(0, 1) != 0) ? NEG : POS;
                bus.Q_comp   = ($urandom_range(0, 1) != 0) ? NEG : POS;
                if ($urandom_range(0, 19) == 0) bus.I_comp = 16'($urandom);
            end
            bus.ready_in = ($urandom_range(0, 3) != 0);
            was_ready    = bus.ready_out;
            cyc();
            if (was_ready && bus.valid_in) pushes++;
            guard++;
        end
        check("rand_pushes", pushes, 1000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
